// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus_ctrl_param slave.
// FSM states, region nibbles and STATUS bit positions.
package bus_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] RGN_CTRL = 4'hA;
  localparam logic [3:0] RGN_STAT = 4'hB;
  localparam logic [3:0] RGN_CNT  = 4'hC;
  localparam logic [3:0] RGN_RSV  = 4'hF;

  localparam int ST_OK  = 31;
  localparam int ST_ERR = 30;
  localparam int ST_WR  = 29;

endpackage

// File: rtl/bus_ctrl_mem.sv
// Byte-strobed 2**ADDR_W x DATA_W memory for bus_ctrl_param.
// Synchronous write port, registered read port; array is not reset.
module bus_ctrl_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int SW = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < SW; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_ctrl_param.sv
// bus_ctrl_param: bus slave with CTRL/STATUS registers, memory and wait states.
// Define BUS_CTRL_TXN_CNT_EN to map a transaction counter at region 0xC.
module bus_ctrl_param
  import bus_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                write,
  input  logic                valid,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                err
);

  localparam int SW = DATA_W / 8;
  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SW-1:0]     req_wstrb;
  logic              req_write;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [SW-1:0]     cur_wstrb;
  logic              cur_write;

  logic in_idle, enter_resp;
  logic [3:0] nib;
  logic is_rsv, is_ctrl, is_stat, is_cnt, is_mem;
  logic clr_hit, mem_sel_q;

  logic [DATA_W-1:0] wmask, ctrl_q, reg_rd, reg_q, mem_q;
  logic [31:0]       status_q;

  // Live bus in IDLE (accept edge), captured request afterwards
  assign in_idle   = state_q == S_IDLE;
  assign cur_addr  = in_idle ? addr  : req_addr;
  assign cur_wdata = in_idle ? wdata : req_wdata;
  assign cur_wstrb = in_idle ? wstrb : req_wstrb;
  assign cur_write = in_idle ? write : req_write;

  assign nib     = cur_addr[ADDR_W-1 -: 4];
  assign is_rsv  = nib == RGN_RSV;
  assign is_ctrl = nib == RGN_CTRL;
  assign is_stat = nib == RGN_STAT;
`ifdef BUS_CTRL_TXN_CNT_EN
  assign is_cnt  = nib == RGN_CNT;
`else
  assign is_cnt  = 1'b0;
`endif
  assign is_mem  = ~(is_rsv | is_ctrl | is_stat | is_cnt);

  if (DATA_W >= 32) begin : g_clr
    assign clr_hit = cur_write & is_stat
                   & cur_wdata[ST_ERR] & cur_wstrb[3];
  end else begin : g_noclr
    assign clr_hit = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (valid) begin
          if (WAIT_STATES == 0 || is_rsv) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else cnt_d = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < SW; b++) begin
      wmask[8*b +: 8] = {8{cur_wstrb[b]}};
    end
  end

`ifdef BUS_CTRL_TXN_CNT_EN
  logic [31:0] txn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txn_q <= '0;
    end else if (enter_resp) begin
      if (cur_write && is_cnt) txn_q <= '0;
      else if (!is_rsv) txn_q <= txn_q + 32'd1;
    end
  end
`endif

  always_comb begin
    reg_rd = '0;
    unique case (1'b1)
      is_ctrl: reg_rd = ctrl_q;
      is_stat: reg_rd = DATA_W'(status_q);
`ifdef BUS_CTRL_TXN_CNT_EN
      is_cnt:  reg_rd = DATA_W'(txn_q);
`endif
      default: reg_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_write <= 1'b0;
      ctrl_q    <= '0;
      status_q  <= '0;
      reg_q     <= '0;
      mem_sel_q <= 1'b0;
    end else begin
      if (in_idle && valid) begin
        req_addr  <= addr;
        req_wdata <= wdata;
        req_wstrb <= wstrb;
        req_write <= write;
      end
      if (enter_resp) begin
        if (cur_write && is_ctrl) begin
          ctrl_q <= (ctrl_q & ~wmask) | (cur_wdata & wmask);
        end
        // A new reserved hit overrides a same-cycle clear
        status_q[ST_OK]  <= ~is_rsv;
        status_q[ST_ERR] <= is_rsv | (status_q[ST_ERR] & ~clr_hit);
        status_q[ST_WR]  <= cur_write;
        status_q[ADDR_W-1:0] <= cur_addr;
        if (!cur_write) begin
          reg_q     <= reg_rd;
          mem_sel_q <= is_mem;
        end
      end
    end
  end

  bus_ctrl_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (enter_resp & cur_write & is_mem),
    .re   (enter_resp & ~cur_write & is_mem),
    .be   (cur_wstrb),
    .addr (cur_addr),
    .wdata(cur_wdata),
    .rdata(mem_q)
  );

  assign rdata = mem_sel_q ? mem_q : reg_q;
  assign ready = state_q == S_RESP;
  assign err   = ready & is_rsv;

endmodule
